arm_decode_stage: RTL and testbench
===================================

Name: arm_decode_stage

Overview:
Registered, parametrised ARM instruction decode stage, placed between fetch and execute in the CPU. It accepts {instruction, pc} over a valid/ready handshake, fully decodes all ARMv4 classes, and buffers decoded bundles in a DEPTH-entry queue that execute drains over a second valid/ready handshake. It supports back-pressure, pipeline flush on branch, pre-rotated immediates and precomputed branch targets.

Parameters:
DEPTH, 2, decoded-bundle queue entries; power of two, ≥1
PC_WIDTH, 32, width of pc and branch target

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  discard all queued entries and the current input beat
in_valid  in  1  fetch offers an instruction
in_ready  out  1  stage can accept; equals (count < DEPTH) && !flush
in_instr  in  32  raw instruction
in_pc  in  PC_WIDTH  address of in_instr
out_valid  out  1  head entry valid (count != 0)
out_ready  in  1  execute consumes head
out_pc  out  PC_WIDTH  pc of head entry
out_cond  out  4  instr[31:28]
out_class  out  4  class code from the shared package
out_opcode  out  4  data-processing opcode instr[24:21]; 0 otherwise
out_set_flags  out  1  S bit instr[20] for data processing and multiply
out_rd, out_rn, out_rm, out_rs  out  4 each  register fields; 0 where unused
out_shift_type  out  2  instr[6:5]
out_shift_amount  out  5  instr[11:7]
out_shift_by_reg  out  1  register-specified shift
out_imm32  out  32  imm8 rotated right by 2*rotate_imm (DP_IMM); zero-extended offset_12 (LS_IMM)
out_pubwl  out  5  load/store and block P,U,B/S,W,L bits instr[24:20]
out_reg_list  out  16  block-transfer register list
out_mem_read, out_mem_write  out  1 each  load / store (incl. block)
out_branch_link  out  1  L bit of branch
out_branch_target  out  PC_WIDTH  pc + 8 + (sign_extend(imm24) << 2), modulo 2^PC_WIDTH
out_undefined  out  1  class == UNDEF
occupancy  out  $clog2(DEPTH+1)  queued entries

Behaviour:
- Reset: queue empty, count 0, read/write pointers 0; out_valid 0, occupancy 0. All bundle outputs read as 0 while empty.
- Push when in_valid && in_ready; pop when out_valid && out_ready. Simultaneous push and pop: count unchanged, both pointers advance. The stage is legal when full: in_ready is 0 and pop frees a slot only on the next cycle (no same-cycle bypass).
- Latency: an instruction accepted at edge N appears at the outputs after edge N (out_valid 1 in cycle N+1 if the queue was empty). FIFO order is preserved.
- Decode is combinational on in_instr and registered on push. Classification, in priority order:
  - MUL: [27:22]=000000 && [7:4]=1001
  - DP_REG_IMMSH: [27:25]=000 && [4]=0
  - DP_REG_REGSH: [27:25]=000 && [7]=0 && [4]=1
  - DP_IMM: 001
  - LS_IMM: 010
  - LS_REG: 011 && [4]=0
  - BLOCK: 100
  - BRANCH: 101
  - SWI: [27:24]=1111
  - UNDEF: everything else, including 000 with [7]=[4]=1 not MUL, 011 with [4]=1, 110 and 1110
- The shift-by-register select comes from bit 4, not bit 20.
- MUL field mapping: rd=[19:16], rn=[15:12], rs=[11:8], rm=[3:0].
- mem_read = L for LS/BLOCK and mem_write = !L for LS/BLOCK; both 0 for every other class.
- Flush has priority over push and pop: next cycle count=0, pointers=0, out_valid=0; an in_valid beat in the flush cycle is dropped. Reset has priority over flush.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally.

Decomposition:
- Package arm_decode_pkg holds the class codes (MUL, DP_REG_IMMSH, DP_REG_REGSH, DP_IMM, LS_IMM, LS_REG, BLOCK, BRANCH, SWI, UNDEF), the shift-type and opcode constants, and the decoded-bundle field widths.
- One sub-module, arm_decode_comb: a purely combinational instr+pc → bundle decoder. The top level holds only the queue and the handshake.

Test Plan:
- 0xE28214FF at pc 0x0 → class DP_IMM, opcode 0100, rd=1, rn=2, imm32=0xFF000000, mem_read=mem_write=0, out_valid one cycle after accept.
- 0xE1A00211 → DP_REG_REGSH, shift_by_reg=1, rs=2, rm=1, shift_type=00, opcode 1101.
- 0xE5343008 → LS_IMM, pubwl=10011, rn=4, rd=3, imm32=0x8, mem_read=1, mem_write=0.
- 0xEBFFFFFE at pc 0x100 → BRANCH, branch_link=1, branch_target=0x100. 0xE7F000F0 → UNDEF, undefined=1.
- DEPTH=2, out_ready=0, three back-to-back beats → in_ready drops after the second; third held. Then raise out_ready → all three emerge in order, occupancy 2,2,1,0 pattern as expected.
- Two entries queued, flush with in_valid=1 → next cycle occupancy=0, out_valid=0, the beat is dropped. Reset asserted mid-stream → same empty state.

Source files
------------

// File: rtl/arm_decode_pkg.sv
// Shared types for the ARM decode stage: instruction class codes, shift/opcode
// constants and the decoded-bundle layout stored in the stage queue.
package arm_decode_pkg;

    typedef enum logic [3:0] {
        CLS_MUL          = 4'd0,
        CLS_DP_REG_IMMSH = 4'd1,
        CLS_DP_REG_REGSH = 4'd2,
        CLS_DP_IMM       = 4'd3,
        CLS_LS_IMM       = 4'd4,
        CLS_LS_REG       = 4'd5,
        CLS_BLOCK        = 4'd6,
        CLS_BRANCH       = 4'd7,
        CLS_SWI          = 4'd8,
        CLS_UNDEF        = 4'd9
    } instr_class_e;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'd0,
        SHIFT_LSR = 2'd1,
        SHIFT_ASR = 2'd2,
        SHIFT_ROR = 2'd3
    } shift_type_e;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam int INSTR_W   = 32;
    localparam int COND_W    = 4;
    localparam int REG_W     = 4;
    localparam int SHAMT_W   = 5;
    localparam int IMM_W     = 32;
    localparam int PUBWL_W   = 5;
    localparam int REGLIST_W = 16;

    // pc and branch target live outside this struct because their width is a parameter.
    typedef struct packed {
        logic [COND_W-1:0]    cond;
        instr_class_e         cls;
        logic [3:0]           opcode;
        logic                 set_flags;
        logic [REG_W-1:0]     rd;
        logic [REG_W-1:0]     rn;
        logic [REG_W-1:0]     rm;
        logic [REG_W-1:0]     rs;
        shift_type_e          shift_type;
        logic [SHAMT_W-1:0]   shift_amount;
        logic                 shift_by_reg;
        logic [IMM_W-1:0]     imm32;
        logic [PUBWL_W-1:0]   pubwl;
        logic [REGLIST_W-1:0] reg_list;
        logic                 mem_read;
        logic                 mem_write;
        logic                 branch_link;
        logic                 undefined;
    } bundle_t;

    function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] n);
        logic [5:0] w_back;
        w_back = 6'd32 - {1'b0, n};
        return (v >> n) | (v << w_back);
    endfunction

endpackage

// File: rtl/arm_decode_comb.sv
// Combinational ARMv4 decoder: classifies one instruction and builds the
// decoded bundle plus the precomputed branch target.
module arm_decode_comb
    import arm_decode_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic [INSTR_W-1:0]  i_instr,
    input  logic [PC_WIDTH-1:0] i_pc,
    output bundle_t             o_bundle,
    output logic [PC_WIDTH-1:0] o_branch_target
);

    instr_class_e        w_cls;
    logic                w_load;
    logic [PC_WIDTH-1:0] w_offset;

    assign w_load   = i_instr[20];
    assign w_offset = PC_WIDTH'($signed({i_instr[23:0], 2'b00}));

    // Priority order matters: MUL and the register-shift forms overlap group 000.
    always_comb begin
        w_cls = CLS_UNDEF;
        if (i_instr[27:22] == 6'b000000 && i_instr[7:4] == 4'b1001) begin
            w_cls = CLS_MUL;
        end else if (i_instr[27:25] == 3'b000 && !i_instr[4]) begin
            w_cls = CLS_DP_REG_IMMSH;
        end else if (i_instr[27:25] == 3'b000 && !i_instr[7]) begin
            w_cls = CLS_DP_REG_REGSH;
        end else begin
            case (i_instr[27:25])
                3'b001:  w_cls = CLS_DP_IMM;
                3'b010:  w_cls = CLS_LS_IMM;
                3'b011:  w_cls = i_instr[4] ? CLS_UNDEF : CLS_LS_REG;
                3'b100:  w_cls = CLS_BLOCK;
                3'b101:  w_cls = CLS_BRANCH;
                3'b111:  w_cls = i_instr[24] ? CLS_SWI : CLS_UNDEF;
                default: w_cls = CLS_UNDEF;
            endcase
        end
    end

    always_comb begin
        o_bundle              = '0;
        o_branch_target       = '0;
        o_bundle.cond         = i_instr[31:28];
        o_bundle.cls          = w_cls;
        o_bundle.shift_type   = shift_type_e'(i_instr[6:5]);
        o_bundle.shift_amount = i_instr[11:7];
        case (w_cls)
            CLS_MUL: begin
                o_bundle.set_flags = i_instr[20];
                o_bundle.rd        = i_instr[19:16];
                o_bundle.rn        = i_instr[15:12];
                o_bundle.rs        = i_instr[11:8];
                o_bundle.rm        = i_instr[3:0];
            end
            CLS_DP_REG_IMMSH, CLS_DP_REG_REGSH, CLS_DP_IMM: begin
                o_bundle.opcode    = i_instr[24:21];
                o_bundle.set_flags = i_instr[20];
                o_bundle.rn        = i_instr[19:16];
                o_bundle.rd        = i_instr[15:12];
                if (w_cls == CLS_DP_IMM) begin
                    o_bundle.imm32 = ror32({24'd0, i_instr[7:0]}, {i_instr[11:8], 1'b0});
                end else begin
                    o_bundle.rm = i_instr[3:0];
                end
                if (w_cls == CLS_DP_REG_REGSH) begin
                    o_bundle.rs           = i_instr[11:8];
                    o_bundle.shift_by_reg = 1'b1;
                end
            end
            CLS_LS_IMM, CLS_LS_REG: begin
                o_bundle.rn        = i_instr[19:16];
                o_bundle.rd        = i_instr[15:12];
                o_bundle.pubwl     = i_instr[24:20];
                o_bundle.mem_read  = w_load;
                o_bundle.mem_write = !w_load;
                if (w_cls == CLS_LS_IMM) begin
                    o_bundle.imm32 = {20'd0, i_instr[11:0]};
                end else begin
                    o_bundle.rm = i_instr[3:0];
                end
            end
            CLS_BLOCK: begin
                o_bundle.rn        = i_instr[19:16];
                o_bundle.pubwl     = i_instr[24:20];
                o_bundle.reg_list  = i_instr[15:0];
                o_bundle.mem_read  = w_load;
                o_bundle.mem_write = !w_load;
            end
            CLS_BRANCH: begin
                o_bundle.branch_link = i_instr[24];
                o_branch_target      = i_pc + PC_WIDTH'(8) + w_offset;
            end
            CLS_UNDEF: begin
                o_bundle.undefined = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/arm_decode_stage.sv
// Decode stage: decodes fetch beats on push and buffers the bundles in a
// DEPTH-entry FIFO drained by execute.
module arm_decode_stage
    import arm_decode_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int PC_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_instr,
    input  logic [PC_WIDTH-1:0]          in_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PC_WIDTH-1:0]          out_pc,
    output logic [3:0]                   out_cond,
    output logic [3:0]                   out_class,
    output logic [3:0]                   out_opcode,
    output logic                         out_set_flags,
    output logic [3:0]                   out_rd,
    output logic [3:0]                   out_rn,
    output logic [3:0]                   out_rm,
    output logic [3:0]                   out_rs,
    output logic [1:0]                   out_shift_type,
    output logic [4:0]                   out_shift_amount,
    output logic                         out_shift_by_reg,
    output logic [31:0]                  out_imm32,
    output logic [4:0]                   out_pubwl,
    output logic [15:0]                  out_reg_list,
    output logic                         out_mem_read,
    output logic                         out_mem_write,
    output logic                         out_branch_link,
    output logic [PC_WIDTH-1:0]          out_branch_target,
    output logic                         out_undefined,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Handshakes: a beat transfers on a rising edge where valid && ready; valid
    // never depends on ready, and flush forces in_ready low so a flushed beat is lost.
    bundle_t             r_mem_bundle [DEPTH];
    logic [PC_WIDTH-1:0] r_mem_pc     [DEPTH];
    logic [PC_WIDTH-1:0] r_mem_target [DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [CNT_W-1:0]    r_count;

    bundle_t             w_dec_bundle;
    logic [PC_WIDTH-1:0] w_dec_target;
    bundle_t             w_head;
    logic [PC_WIDTH-1:0] w_head_pc;
    logic [PC_WIDTH-1:0] w_head_target;
    logic                w_push;
    logic                w_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (DEPTH == 1) ? '0 : p + 1'b1;
    endfunction

    arm_decode_comb #(
        .PC_WIDTH(PC_WIDTH)
    ) u_decode (
        .i_instr         (in_instr),
        .i_pc            (in_pc),
        .o_bundle        (w_dec_bundle),
        .o_branch_target (w_dec_target)
    );

    assign in_ready  = (r_count < CNT_W'(DEPTH)) && !flush;
    assign out_valid = (r_count != '0);
    assign occupancy = r_count;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= ptr_next(r_wptr);
            if (w_pop)  r_rptr <= ptr_next(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_bundle[r_wptr] <= w_dec_bundle;
            r_mem_pc[r_wptr]     <= in_pc;
            r_mem_target[r_wptr] <= w_dec_target;
        end
    end

    // Gate the head so an empty queue presents an all-zero bundle.
    assign w_head        = out_valid ? r_mem_bundle[r_rptr] : '0;
    assign w_head_pc     = out_valid ? r_mem_pc[r_rptr]     : '0;
    assign w_head_target = out_valid ? r_mem_target[r_rptr] : '0;

    assign out_pc            = w_head_pc;
    assign out_cond          = w_head.cond;
    assign out_class         = w_head.cls;
    assign out_opcode        = w_head.opcode;
    assign out_set_flags     = w_head.set_flags;
    assign out_rd            = w_head.rd;
    assign out_rn            = w_head.rn;
    assign out_rm            = w_head.rm;
    assign out_rs            = w_head.rs;
    assign out_shift_type    = w_head.shift_type;
    assign out_shift_amount  = w_head.shift_amount;
    assign out_shift_by_reg  = w_head.shift_by_reg;
    assign out_imm32         = w_head.imm32;
    assign out_pubwl         = w_head.pubwl;
    assign out_reg_list      = w_head.reg_list;
    assign out_mem_read      = w_head.mem_read;
    assign out_mem_write     = w_head.mem_write;
    assign out_branch_link   = w_head.branch_link;
    assign out_branch_target = w_head_target;
    assign out_undefined     = w_head.undefined;

endmodule

// File: tb/tb_arm_decode_stage.sv
// Bench for arm_decode_stage: directed instruction vectors against a behavioural
// decode/queue model, checked every cycle, plus literal expectations.
module tb_arm_decode_stage;
    import arm_decode_pkg::*;

    localparam int DEPTH = 2;
    localparam int PW    = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]   in_instr;
    logic [PW-1:0] in_pc, out_pc, out_branch_target;
    logic [3:0]    out_cond, out_class, out_opcode, out_rd, out_rn, out_rm, out_rs;
    logic          out_set_flags, out_shift_by_reg, out_mem_read, out_mem_write;
    logic          out_branch_link, out_undefined;
    logic [1:0]    out_shift_type;
    logic [4:0]    out_shift_amount, out_pubwl;
    logic [31:0]   out_imm32;
    logic [15:0]   out_reg_list;
    logic [1:0]    occupancy;

    arm_decode_stage #(.DEPTH(DEPTH), .PC_WIDTH(PW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_cond(out_cond), .out_class(out_class), .out_opcode(out_opcode),
        .out_set_flags(out_set_flags), .out_rd(out_rd), .out_rn(out_rn),
        .out_rm(out_rm), .out_rs(out_rs), .out_shift_type(out_shift_type),
        .out_shift_amount(out_shift_amount), .out_shift_by_reg(out_shift_by_reg),
        .out_imm32(out_imm32), .out_pubwl(out_pubwl), .out_reg_list(out_reg_list),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_branch_link(out_branch_link), .out_branch_target(out_branch_target),
        .out_undefined(out_undefined), .occupancy(occupancy)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  cond, cls, opcode;
        logic        sf;
        logic [3:0]  rd, rn, rm, rs;
        logic [1:0]  st;
        logic [4:0]  sa;
        logic        sbr;
        logic [31:0] imm;
        logic [4:0]  pubwl;
        logic [15:0] rl;
        logic        mr, mw, bl;
        logic [31:0] bt;
        logic        und;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    bit   started = 0;

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t        e;
        logic [2:0]  grp;
        logic [31:0] imm8;
        logic [63:0] dbl;
        int          off;
        e = '0;
        grp = ins[27:25];
        e.pc = pc;
        e.cond = ins[31:28];
        e.st = ins[6:5];
        e.sa = ins[11:7];
        if (ins[27:22] == 6'd0 && ins[7:4] == 4'h9)  e.cls = CLS_MUL;
        else if (grp == 3'd0 && ins[4] == 1'b0)      e.cls = CLS_DP_REG_IMMSH;
        else if (grp == 3'd0 && ins[7] == 1'b0)      e.cls = CLS_DP_REG_REGSH;
        else if (grp == 3'd1)                        e.cls = CLS_DP_IMM;
        else if (grp == 3'd2)                        e.cls = CLS_LS_IMM;
        else if (grp == 3'd3 && ins[4] == 1'b0)      e.cls = CLS_LS_REG;
        else if (grp == 3'd4)                        e.cls = CLS_BLOCK;
        else if (grp == 3'd5)                        e.cls = CLS_BRANCH;
        else if (ins[27:24] == 4'hF)                 e.cls = CLS_SWI;
        else                                         e.cls = CLS_UNDEF;

        if (e.cls == CLS_MUL) begin
            e.sf = ins[20]; e.rd = ins[19:16]; e.rn = ins[15:12];
            e.rs = ins[11:8]; e.rm = ins[3:0];
        end
        if (e.cls == CLS_DP_REG_IMMSH || e.cls == CLS_DP_REG_REGSH || e.cls == CLS_DP_IMM) begin
            e.opcode = ins[24:21]; e.sf = ins[20];
            e.rn = ins[19:16]; e.rd = ins[15:12];
        end
        if (e.cls == CLS_DP_REG_IMMSH) e.rm = ins[3:0];
        if (e.cls == CLS_DP_REG_REGSH) begin
            e.rm = ins[3:0]; e.rs = ins[11:8]; e.sbr = 1'b1;
        end
        if (e.cls == CLS_DP_IMM) begin
            imm8 = {24'd0, ins[7:0]};
            dbl = {imm8, imm8} >> (2 * ins[11:8]);
            e.imm = dbl[31:0];
        end
        if (e.cls == CLS_LS_IMM || e.cls == CLS_LS_REG || e.cls == CLS_BLOCK) begin
            e.rn = ins[19:16]; e.pubwl = ins[24:20];
            e.mr = ins[20]; e.mw = ~ins[20];
        end
        if (e.cls == CLS_LS_IMM) begin e.rd = ins[15:12]; e.imm = 32'(ins[11:0]); end
        if (e.cls == CLS_LS_REG) begin e.rd = ins[15:12]; e.rm = ins[3:0]; end
        if (e.cls == CLS_BLOCK) e.rl = ins[15:0];
        if (e.cls == CLS_BRANCH) begin
            e.bl = ins[24];
            off = int'(ins[23:0]);
            if (off >= 8388608) off = off - 16777216;
            e.bt = pc + 32'd8 + 32'(off * 4);
        end
        if (e.cls == CLS_UNDEF) e.und = 1'b1;
        return e;
    endfunction

    always @(posedge clk) begin
        bit do_push, do_pop;
        if (reset) begin
            exp_q.delete();
            started = 1;
        end else if (started) begin
            if (flush) begin
                exp_q.delete();
            end else begin
                do_pop  = (exp_q.size() != 0) && out_ready;
                do_push = in_valid && (exp_q.size() < DEPTH);
                if (do_pop)  void'(exp_q.pop_front());
                if (do_push) exp_q.push_back(model(in_instr, in_pc));
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t h;
        if (started && !reset) begin
            h = (exp_q.size() != 0) ? exp_q[0] : '0;
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
            chk("in_ready",  32'(in_ready),  32'((exp_q.size() < DEPTH) && !flush));
            chk("pc", out_pc, h.pc);
            chk("cond", 32'(out_cond), 32'(h.cond));
            chk("class", 32'(out_class), 32'(h.cls));
            chk("opcode", 32'(out_opcode), 32'(h.opcode));
            chk("set_flags", 32'(out_set_flags), 32'(h.sf));
            chk("rd", 32'(out_rd), 32'(h.rd));
            chk("rn", 32'(out_rn), 32'(h.rn));
            chk("rm", 32'(out_rm), 32'(h.rm));
            chk("rs", 32'(out_rs), 32'(h.rs));
            chk("shift_type", 32'(out_shift_type), 32'(h.st));
            chk("shift_amount", 32'(out_shift_amount), 32'(h.sa));
            chk("shift_by_reg", 32'(out_shift_by_reg), 32'(h.sbr));
            chk("imm32", out_imm32, h.imm);
            chk("pubwl", 32'(out_pubwl), 32'(h.pubwl));
            chk("reg_list", 32'(out_reg_list), 32'(h.rl));
            chk("mem_read", 32'(out_mem_read), 32'(h.mr));
            chk("mem_write", 32'(out_mem_write), 32'(h.mw));
            chk("branch_link", 32'(out_branch_link), 32'(h.bl));
            chk("branch_target", out_branch_target, h.bt);
            chk("undefined", 32'(out_undefined), 32'(h.und));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        int n;
        bit done;
        n = 0;
        done = 0;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        while (!done && n < 50) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout instr=%h expected accept within 50 cycles", ins);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (out_valid) begin
            errors++;
            $display("FAIL drain_timeout out_valid=1 expected 0 within 20 cycles");
        end
    endtask

    logic [31:0] vec_ins [10] = '{32'hE0012392, 32'hE0812103, 32'hE8BD4010, 32'hE7812003,
                                  32'hEF000000, 32'hEAFFFFFD, 32'h0E000010, 32'hE1A00090,
                                  32'hE3B0F20F, 32'h15943FFF};
    logic [31:0] vec_pc  [10] = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20,
                                  32'h200, 32'h24, 32'h28, 32'h2C, 32'hFFFFFFF0};

    initial begin
        exp_t e;
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;

        // pin the model against hand-decoded values
        e = model(32'hE28214FF, 32'h0);
        chk("pin_dpimm_class", 32'(e.cls), 32'(CLS_DP_IMM));
        chk("pin_dpimm_imm", e.imm, 32'hFF000000);
        chk("pin_dpimm_regs", {24'd0, e.opcode, e.rd, e.rn}, 32'h00000412);
        e = model(32'hE1A00211, 32'h0);
        chk("pin_regsh", {20'd0, e.cls, e.opcode, e.rs, e.rm, e.sbr, 3'd0} , {20'd0, 4'(CLS_DP_REG_REGSH), 4'hD, 4'h2, 4'h1, 1'b1, 3'd0});
        e = model(32'hE5343008, 32'h0);
        chk("pin_ls", {e.cls, e.pubwl, e.rn, e.rd, e.mr, e.mw, 10'd0}, {4'(CLS_LS_IMM), 5'b10011, 4'h4, 4'h3, 1'b1, 1'b0, 10'd0});
        chk("pin_ls_imm", e.imm, 32'h8);
        e = model(32'hEBFFFFFE, 32'h100);
        chk("pin_bl_target", e.bt, 32'h100);
        chk("pin_bl_link", 32'(e.bl), 32'd1);
        e = model(32'hE7F000F0, 32'h0);
        chk("pin_undef", {28'd0, e.cls}, 32'(CLS_UNDEF));
        e = model(32'hEAFFFFFD, 32'h200);
        chk("pin_b_back", e.bt, 32'h1FC);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_occupancy", 32'(occupancy), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // single beats with execute ready: one-cycle latency, literal checks on head
        out_ready = 1'b1;
        send(32'hE28214FF, 32'h0);
        @(negedge clk);
        chk("lit_valid_after_accept", 32'(out_valid), 32'd1);
        chk("lit_dpimm_imm", out_imm32, 32'hFF000000);
        chk("lit_dpimm_class", 32'(out_class), 32'(CLS_DP_IMM));
        @(posedge clk); #1;
        send(32'hE1A00211, 32'h4);
        send(32'hE5343008, 32'h8);
        @(negedge clk);
        chk("lit_ls_read", {31'd0, out_mem_read}, 32'd1);
        @(posedge clk); #1;
        send(32'hEBFFFFFE, 32'h100);
        @(negedge clk);
        chk("lit_branch_target", out_branch_target, 32'h100);
        @(posedge clk); #1;
        send(32'hE7F000F0, 32'h104);
        drain();

        // back-pressure: three beats, execute stalled
        out_ready = 1'b0;
        send(32'hE3A01001, 32'h300);
        send(32'hE3A02002, 32'h304);
        in_valid = 1'b1; in_instr = 32'hE3A03003; in_pc = 32'h308;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("lit_full_ready", 32'(in_ready), 32'd0);
        chk("lit_full_occ", 32'(occupancy), 32'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'hE3A03003, 32'h308);
        drain();

        // flush with a beat offered in the same cycle
        out_ready = 1'b0;
        send(32'hE3A04004, 32'h400);
        send(32'hE3A05005, 32'h404);
        in_valid = 1'b1; in_instr = 32'hE3A06006; in_pc = 32'h408; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("lit_flush_occ", 32'(occupancy), 32'd0);
        chk("lit_flush_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // reset mid-stream
        send(32'hE3A07007, 32'h500);
        send(32'hE3A08008, 32'h504);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("lit_reset_occ", 32'(occupancy), 32'd0);
        chk("lit_reset_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // remaining classes with irregular draining
        for (int i = 0; i < 10; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (exp_q.size() == DEPTH) out_ready = 1'b1;
            send(vec_ins[i], vec_pc[i]);
        end
        drain();
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
